apb3_cmd_host: RTL and testbench

- Converts a simple valid/ready command stream (read/write, address, data) into single APB3 transfers.
- Drives the host side of an apb3_intf bundle and returns one response per command on a valid/ready response stream.
- Sits between internal masters (CSR bridges, debug ports) and APB3 peripheral fabrics.
- Adds a bus timeout so a hung agent cannot stall the master forever.

---
 rtl/apb3_cmd_host_pkg.sv | 22 ++
 rtl/apb3_cmd_host_if.sv | 26 ++
 rtl/apb3_cmd_host.sv | 173 +++++++++++++++++
 tb/tb_apb3_cmd_host.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_cmd_host_pkg.sv
// Shared types and constants for the APB3 command host: FSM state encoding,
// the response record used by consumers of the response stream, and defaults.
package apb3_pkg;

  localparam int APB3_TIMEOUT_DEFAULT = 256;
  localparam int APB3_RSP_DWIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb3_state_e;

  // Response record at the default data width; rdata is 0 for writes and timeouts.
  typedef struct packed {
    logic [APB3_RSP_DWIDTH-1:0] rdata;
    logic                       err;
    logic                       timeout;
  } apb3_rsp_t;

endpackage

// File: rtl/apb3_cmd_host_if.sv
// APB3 signal bundle; host drives the request side, agent drives the completion side.
interface apb3_intf #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport host (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport agent (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb3_cmd_host.sv
// Turns a valid/ready command stream into single APB3 transfers and returns one
// response per command, with a bus timeout that aborts transfers a hung agent never completes.
module apb3_cmd_host
  import apb3_pkg::*;
#(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = APB3_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  apb3_intf.host            apb,
  output apb3_state_e       dbg_state
);

  // Both streams: a beat transfers on a rising edge where valid && ready; a producer
  // holds valid and payload stable until then, and ready never waits on valid.

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  apb3_state_e       state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic cmd_fire;
  logic rsp_fire;
  logic timeout_hit;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid_q && rsp_ready;

  // Abort on the last allowed waiting cycle; a same-cycle pready still completes normally.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !apb.pready && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb.pready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; everything holds unless the state says otherwise
  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          psel_d   = 1'b1;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (!apb.pready && (cnt_q != CNT_SAT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (apb.pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : apb.prdata;
          rsp_err_d     = apb.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb3_cmd_host.sv
// Bench for apb3_cmd_host: directed scenarios plus random transfers, each checked
// against a transaction-level model of what the response and bus phase lengths should be.
module tb_apb3_cmd_host;
  import apb3_pkg::*;

  localparam int TO = 8;
  localparam int W  = $bits(apb3_rsp_t);

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  apb3_state_e dbg_state;

  apb3_intf #(.DWIDTH(32), .AWIDTH(32)) apb ();

  apb3_cmd_host #(
    .DWIDTH(32), .AWIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb),
    .dbg_state   (dbg_state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic        nxt_wr;
  logic [31:0] nxt_addr, nxt_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a transfer completes on its pready cycle unless the agent
  // waits TO cycles or more, in which case the host gives up after TO ACCESS cycles.
  function automatic apb3_rsp_t model_rsp(input logic wr, input int waits,
                                          input logic [31:0] rd, input logic slverr);
    apb3_rsp_t r;
    if (waits >= TO) begin
      r.rdata = 32'h0; r.err = 1'b1; r.timeout = 1'b1;
    end else begin
      r.rdata = wr ? 32'h0 : rd; r.err = slverr; r.timeout = 1'b0;
    end
    return r;
  endfunction

  function automatic int model_access_len(input int waits);
    return (waits >= TO) ? TO : waits + 1;
  endfunction

  task automatic agent_noise();
    apb.pready  = 1'($urandom);
    apb.prdata  = $urandom;
    apb.pslverr = 1'($urandom);
  endtask

  // Driver: one full transfer, entered and left on a falling edge with the DUT idle
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rd, input logic slverr,
                         input int hold, input bit drive_next, output int hs_wait);
    apb3_rsp_t    got;
    logic [W-1:0] exp_bits;
    int           acc;
    exp_q.push_back(model_rsp(wr, waits, rd, slverr));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    hs_wait = 0;
    while (cmd_ready !== 1'b1 && hs_wait < 20) begin
      @(negedge clk); hs_wait++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    agent_noise();
    check("setup_psel", apb.psel, 1);
    check("setup_penable", apb.penable, 0);
    check("setup_state", dbg_state, SETUP);
    check("setup_paddr", apb.paddr, addr);
    check("setup_pwrite", apb.pwrite, wr);
    check("setup_pwdata", apb.pwdata, wdata);
    check("setup_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    acc = 0;
    while (apb.psel === 1'b1 && apb.penable === 1'b1 && acc < 40) begin
      check("access_paddr", apb.paddr, addr);
      check("access_pwdata", apb.pwdata, wdata);
      check("access_pwrite", apb.pwrite, wr);
      check("access_rsp_valid", rsp_valid, 0);
      apb.pready  = (acc == waits);
      apb.prdata  = apb.pready ? rd : $urandom;
      apb.pslverr = apb.pready ? slverr : 1'($urandom);
      @(negedge clk);
      acc++;
    end
    check("access_len", acc, model_access_len(waits));
    check("resp_psel", apb.psel, 0);
    check("resp_penable", apb.penable, 0);
    exp_bits = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      agent_noise();
      got.rdata = rsp_rdata; got.err = rsp_err; got.timeout = rsp_timeout;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_payload", got, exp_bits);
      check("resp_cmd_ready", cmd_ready, 0);
      if (i < hold) begin
        if (drive_next) begin
          cmd_valid = 1'b1; cmd_write = nxt_wr; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
        end
        @(negedge clk);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_cmd_ready", cmd_ready, 1);
  endtask

  task automatic reset_mid_access();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050; cmd_wdata = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    apb.pready = 1'b0;
    @(negedge clk);
    check("rstmid_state", dbg_state, ACCESS);
    apb.pready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_psel", apb.psel, 0);
    check("rstmid_penable", apb.penable, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_state", dbg_state, IDLE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      agent_noise();
      check("rel_no_rsp", rsp_valid, 0);
      check("rel_no_psel", apb.psel, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hs;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
    nxt_wr = 1'b0; nxt_addr = '0; nxt_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", apb.psel, 0);
    check("rst_penable", apb.penable, 0);
    check("rst_pwrite", apb.pwrite, 0);
    check("rst_paddr", apb.paddr, 0);
    check("rst_pwdata", apb.pwdata, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write, multi-wait read, slave error, timeout then recovery
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, hs);
    run_txn(1'b0, 32'h0000_0020, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 1'b0, hs);
    run_txn(1'b0, 32'h0000_0030, 32'h0, 1, 32'hCAFE_0001, 1'b1, 1, 1'b0, hs);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 50, 32'hAAAA_5555, 1'b0, 0, 1'b0, hs);
    run_txn(1'b1, 32'h0000_0044, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 0, 1'b0, hs);
    // pready on the last allowed cycle beats the timeout
    run_txn(1'b0, 32'h0000_0048, 32'h0, TO - 1, 32'h7777_8888, 1'b0, 0, 1'b0, hs);

    // Response back-pressure with a second command waiting
    nxt_wr = 1'b1; nxt_addr = 32'h0000_0060; nxt_wdata = 32'h5A5A_A5A5;
    run_txn(1'b0, 32'h0000_0058, 32'h0, 2, 32'h1111_2222, 1'b0, 10, 1'b1, hs);
    run_txn(nxt_wr, nxt_addr, nxt_wdata, 0, 32'h0, 1'b0, 0, 1'b0, hs);
    check("bp_accept_next_cycle", hs, 0);

    reset_mid_access();

    for (int n = 0; n < 25; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 10)), $urandom,
              1'($urandom), int'($urandom_range(0, 3)), 1'b0, hs);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
